// File: rtl/dac_update_sequencer.sv
// Sequences one synchronous DAC update: SPI launch, drain wait, LDAC pulse, BUSY wait.
module dac_update_sequencer #(
    parameter int unsigned DACN         = 2,
    parameter int unsigned LDAC_CYCLES  = 2,
    parameter int unsigned SPI_TIMEOUT  = 4096,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [DACN-1:0] channel_mask,
    output logic            ready,
    output logic            done,
    output logic            error,
    output logic [1:0]      error_code,
    output logic [DACN-1:0] active_mask,
    input  logic [DACN-1:0] fifo_empty,
    input  logic [DACN-1:0] spi_busy,
    output logic [DACN-1:0] spi_start_transmit,
    input  logic [DACN-1:0] dac_busy_n,
    output logic [DACN-1:0] dac_ldac_n
);

    localparam int unsigned TMAX  = (SPI_TIMEOUT > BUSY_TIMEOUT) ? SPI_TIMEOUT : BUSY_TIMEOUT;
    localparam int unsigned CNT_W = $clog2(TMAX) + 1;

    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] SPI_GUARD  = CNT_W'(2);
    localparam logic [CNT_W-1:0] BUSY_GUARD = CNT_W'(1);
    localparam logic [CNT_W-1:0] SPI_LAST   = CNT_W'(SPI_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_CYCLES - 1);

    localparam logic [1:0] CODE_OK       = 2'b00;
    localparam logic [1:0] CODE_EMPTY    = 2'b01;
    localparam logic [1:0] CODE_SPI_TO   = 2'b10;
    localparam logic [1:0] CODE_BUSY_TO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_SPI,
        S_LDAC,
        S_WAIT_BUSY,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;
    logic [DACN-1:0]   active_q, active_d;
    logic [DACN-1:0]   launch_q, launch_d;
    logic [DACN-1:0]   ldac_n_q, ldac_n_d;
    logic [DACN-1:0]   busy_meta_q, busy_sync_q;

    logic [DACN-1:0]   req_mask;
    logic              spi_drained;
    logic              busy_released;

    // Two-flop synchroniser for the asynchronous DAC BUSY inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_meta_q <= '1;
            busy_sync_q <= '1;
        end else begin
            busy_meta_q <= dac_busy_n;
            busy_sync_q <= busy_meta_q;
        end
    end

    // Completion conditions for the two wait states
    always_comb begin
        req_mask      = channel_mask & ~fifo_empty;
        spi_drained   = ((spi_busy & active_q) == '0) && ((fifo_empty & active_q) == active_q);
        busy_released = &(busy_sync_q | ~active_q);
    end

    // Next-state, shared counter and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        code_d   = code_q;
        active_d = active_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    active_d = req_mask;
                    code_d   = CODE_OK;
                    if (req_mask == '0) begin
                        code_d  = CODE_EMPTY;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_SPI;
            end
            S_WAIT_SPI: begin
                // Completion is checked first so it wins over a simultaneous timeout
                if ((cnt_q >= SPI_GUARD) && spi_drained) begin
                    cnt_d   = '0;
                    state_d = S_LDAC;
                end else if (cnt_q >= SPI_LAST) begin
                    code_d  = CODE_SPI_TO;
                    state_d = S_ERR;
                end
            end
            S_LDAC: begin
                if (cnt_q >= LDAC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if ((cnt_q >= BUSY_GUARD) && busy_released) begin
                    state_d = S_DONE;
                end else if (cnt_q >= BUSY_LAST) begin
                    code_d  = CODE_BUSY_TO;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register
        ready_d  = (state_d == S_IDLE);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERR);
        launch_d = (state_d == S_LAUNCH) ? active_d : '0;
        ldac_n_d = (state_d == S_LDAC) ? ~active_d : '1;
    end

    // State, counter and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= CODE_OK;
            active_q <= '0;
            launch_q <= '0;
            ldac_n_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            error_q  <= error_d;
            code_q   <= code_d;
            active_q <= active_d;
            launch_q <= launch_d;
            ldac_n_q <= ldac_n_d;
        end
    end

    assign ready              = ready_q;
    assign done               = done_q;
    assign error              = error_q;
    assign error_code         = code_q;
    assign active_mask        = active_q;
    assign spi_start_transmit = launch_q;
    assign dac_ldac_n         = ldac_n_q;

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench for dac_update_sequencer with SPI/FIFO and DAC behavioural models.
module tb_dac_update_sequencer;

    localparam int unsigned DACN         = 2;
    localparam int unsigned LDAC_CYCLES  = 2;
    localparam int unsigned SPI_TIMEOUT  = 64;
    localparam int unsigned BUSY_TIMEOUT = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            start;
    logic [DACN-1:0] channel_mask;
    logic            ready;
    logic            done;
    logic            error;
    logic [1:0]      error_code;
    logic [DACN-1:0] active_mask;
    logic [DACN-1:0] fifo_empty;
    logic [DACN-1:0] spi_busy;
    logic [DACN-1:0] spi_start_transmit;
    logic [DACN-1:0] dac_busy_n;
    logic [DACN-1:0] dac_ldac_n;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [1:0] active;
        logic [1:0] launch;
        logic [7:0] pulses;
        logic [7:0] ldac_cycles;
        logic [1:0] ldac_mask;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_acc;

    int checks = 0;
    int errors = 0;

    int spi_len  = 30;
    int dac_len  = 5;
    bit spi_stuck = 1'b0;
    bit dac_stuck = 1'b0;
    int spi_cnt [DACN];
    int dac_cnt [DACN];

    dac_update_sequencer #(
        .DACN         (DACN),
        .LDAC_CYCLES  (LDAC_CYCLES),
        .SPI_TIMEOUT  (SPI_TIMEOUT),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .channel_mask       (channel_mask),
        .ready              (ready),
        .done               (done),
        .error              (error),
        .error_code         (error_code),
        .active_mask        (active_mask),
        .fifo_empty         (fifo_empty),
        .spi_busy           (spi_busy),
        .spi_start_transmit (spi_start_transmit),
        .dac_busy_n         (dac_busy_n),
        .dac_ldac_n         (dac_ldac_n)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI transmitter + FIFO: busy for spi_len cycles after launch, then FIFO reads empty
    task automatic spi_model();
        forever begin
            @(negedge clock);
            if (!spi_stuck) begin
                for (int i = 0; i < DACN; i++) begin
                    if (spi_start_transmit[i]) begin
                        spi_cnt[i]  = spi_len;
                        spi_busy[i] = 1'b1;
                    end else if (spi_cnt[i] > 0) begin
                        spi_cnt[i]--;
                        if (spi_cnt[i] == 0) begin
                            spi_busy[i]   = 1'b0;
                            fifo_empty[i] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // DAC: BUSY low while LDAC is low and for dac_len cycles afterwards
    task automatic dac_model();
        forever begin
            @(negedge clock);
            for (int i = 0; i < DACN; i++) begin
                if (!dac_ldac_n[i]) begin
                    dac_cnt[i]    = dac_len;
                    dac_busy_n[i] = 1'b0;
                end else if (!dac_stuck && dac_cnt[i] > 0) begin
                    dac_cnt[i]--;
                    if (dac_cnt[i] == 0) dac_busy_n[i] = 1'b1;
                end
            end
        end
    endtask

    // Collects launch/LDAC activity of one update and posts it when done or error appears
    task automatic monitor();
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_acc = '0;
            end else begin
                mon_acc.launch = mon_acc.launch | spi_start_transmit;
                if (spi_start_transmit != '0) mon_acc.pulses = mon_acc.pulses + 8'd1;
                if (dac_ldac_n != '1) begin
                    mon_acc.ldac_cycles = mon_acc.ldac_cycles + 8'd1;
                    mon_acc.ldac_mask   = mon_acc.ldac_mask | ~dac_ldac_n;
                end
                if (done || error) begin
                    mon_acc.done   = done;
                    mon_acc.err    = error;
                    mon_acc.code   = error_code;
                    mon_acc.active = active_mask;
                    obs_q.push_back(mon_acc);
                    mon_acc = '0;
                end
            end
        end
    endtask

    // Pulses start and pushes the expected outcome of the update it begins
    task automatic start_update(input logic [1:0] mask, input logic [1:0] code_exp,
                                input bit is_err, input int ldac_exp);
        res_t e;
        logic [1:0] act;
        @(posedge clock); #1;
        act = mask & ~fifo_empty;
        e = '0;
        e.done        = !is_err;
        e.err         = is_err;
        e.code        = (act == 2'b00) ? 2'b01 : code_exp;
        e.active      = act;
        e.launch      = act;
        e.pulses      = (act == 2'b00) ? 8'd0 : 8'd1;
        e.ldac_cycles = (act == 2'b00) ? 8'd0 : 8'(ldac_exp);
        e.ldac_mask   = (ldac_exp == 0) ? 2'b00 : act;
        exp_q.push_back(e);
        start        = 1'b1;
        channel_mask = mask;
        @(posedge clock); #1;
        start = 1'b0;
        chk("ready_low_after_start", 32'(ready), 32'((act == 2'b00) ? 1'b0 : 1'b0));
        chk("launch_latency", 32'(spi_start_transmit), 32'(act));
        chk("empty_done_latency", 32'(done), 32'(act == 2'b00));
    endtask

    // Waits (bounded) for one update outcome and compares it with the scoreboard head
    task automatic wait_result(input int max_cycles, output int n);
        res_t o, e;
        n = 0;
        while (obs_q.size() == 0 && n < max_cycles) begin
            @(negedge clock); #1;
            n++;
        end
        chk("result_arrived", 32'(obs_q.size() > 0), 32'd1);
        chk("expect_pending", 32'(exp_q.size() > 0), 32'd1);
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("done_pulse",  32'(o.done),        32'(e.done));
        chk("error_pulse", 32'(o.err),         32'(e.err));
        chk("error_code",  32'(o.code),        32'(e.code));
        chk("active_mask", 32'(o.active),      32'(e.active));
        chk("launch_mask", 32'(o.launch),      32'(e.launch));
        chk("launch_cnt",  32'(o.pulses),      32'(e.pulses));
        chk("ldac_cycles", 32'(o.ldac_cycles), 32'(e.ldac_cycles));
        chk("ldac_mask",   32'(o.ldac_mask),   32'(e.ldac_mask));
        @(posedge clock); #1;
        chk("ready_back", 32'(ready), 32'd1);
        chk("pulse_single", 32'({done, error}), 32'd0);
        chk("ldac_idle", 32'(dac_ldac_n), 32'h3);
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        start        = 1'b0;
        channel_mask = '0;
        fifo_empty   = 2'b00;
        spi_busy     = 2'b00;
        dac_busy_n   = 2'b11;
        mon_acc      = '0;
        for (int i = 0; i < DACN; i++) begin
            spi_cnt[i] = 0;
            dac_cnt[i] = 0;
        end
        fork
            spi_model();
            dac_model();
            monitor();
        join_none

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready",  32'(ready),              32'd1);
        chk("rst_done",   32'(done),               32'd0);
        chk("rst_error",  32'(error),              32'd0);
        chk("rst_code",   32'(error_code),         32'd0);
        chk("rst_active", 32'(active_mask),        32'd0);
        chk("rst_launch", 32'(spi_start_transmit), 32'd0);
        chk("rst_ldac",   32'(dac_ldac_n),         32'h3);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // 1: both channels, SPI busy 30, BUSY low 5; a second start mid-update is dropped
        fifo_empty = 2'b00;
        start_update(2'b11, 2'b00, 1'b0, LDAC_CYCLES);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; channel_mask = 2'b01;
        @(posedge clock); #1;
        start = 1'b0;
        wait_result(300, n);
        repeat (10) @(posedge clock);
        #1;
        chk("no_queued_start", 32'(obs_q.size()), 32'd0);
        chk("hold_code",   32'(error_code),  32'd0);
        chk("hold_active", 32'(active_mask), 32'h3);

        // 2: channel 0 FIFO empty -> only channel 1 takes part
        fifo_empty = 2'b01;
        start_update(2'b11, 2'b00, 1'b0, LDAC_CYCLES);
        wait_result(300, n);

        // 3: nothing to send -> done next cycle with code 01
        fifo_empty = 2'b01;
        start_update(2'b01, 2'b01, 1'b0, 0);
        wait_result(20, n);
        chk("empty_latency", 32'(n), 32'd1);

        // 4: SPI stuck busy -> SPI timeout, no LDAC
        fifo_empty = 2'b00;
        spi_stuck  = 1'b1;
        spi_busy   = 2'b11;
        start_update(2'b11, 2'b10, 1'b1, 0);
        wait_result(300, n);
        chk("spi_to_min", 32'(n >= int'(SPI_TIMEOUT)), 32'd1);
        chk("spi_to_max", 32'(n <= int'(SPI_TIMEOUT) + 4), 32'd1);
        spi_stuck = 1'b0;
        spi_busy  = 2'b00;
        for (int i = 0; i < DACN; i++) spi_cnt[i] = 0;

        // 5: DAC BUSY stuck low -> BUSY timeout after the LDAC pulse
        fifo_empty = 2'b00;
        dac_stuck  = 1'b1;
        start_update(2'b11, 2'b11, 1'b1, LDAC_CYCLES);
        wait_result(300, n);
        dac_stuck  = 1'b0;
        repeat (10) @(posedge clock);

        // 6: reset asserted during LDAC
        fifo_empty = 2'b00;
        start_update(2'b11, 2'b00, 1'b0, LDAC_CYCLES);
        n = 0;
        while (dac_ldac_n == 2'b11 && n < 300) begin
            @(negedge clock); #1;
            n++;
        end
        chk("ldac_reached", 32'(dac_ldac_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ldac",   32'(dac_ldac_n),  32'h3);
        chk("mid_rst_ready",  32'(ready),       32'd1);
        chk("mid_rst_active", 32'(active_mask), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("no_result_after_rst", 32'(obs_q.size()), 32'd0);
        chk("idle_after_rst", 32'(ready), 32'd1);

        // Recovery: a normal single-channel update after reset
        fifo_empty = 2'b10;
        start_update(2'b11, 2'b00, 1'b0, LDAC_CYCLES);
        wait_result(300, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
